// File: rtl/cla_acc_if.sv
// cla_acc_if -- bus bundle for the CLA accumulator controller.
//   clear              synchronous clear request
//   in_valid/in_ready  operand handshake, in_data is the operand byte
//   add_a/add_b        operands presented to the external 8-bit CLA adder
//   add_sum/add_cout   adder result and carry-out
//   acc/out_valid      accumulator value and one-cycle update pulse
//   carry_cnt/ovf      saturating carry count and sticky overflow flag
// slave modport: the controller; master modport: the surrounding logic/adder.
interface cla_acc_if;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic [7:0] add_sum;
  logic       add_cout;
  logic [7:0] acc;
  logic       out_valid;
  logic [7:0] carry_cnt;
  logic       ovf;

  modport slave (
    input  clear, in_valid, in_data, add_sum, add_cout,
    output in_ready, add_a, add_b, acc, out_valid, carry_cnt, ovf
  );

  modport master (
    output clear, in_valid, in_data, add_sum, add_cout,
    input  in_ready, add_a, add_b, acc, out_valid, carry_cnt, ovf
  );
endinterface

// File: rtl/cla_acc_ctrl.sv
// cla_acc_ctrl -- sequences an external 8-bit carry-lookahead adder to
// accumulate a stream of operand bytes.
// An accepted operand is held on add_b (accumulator on add_a) for
// SETTLE_CYCLES edges, then add_sum/add_cout are captured into acc.
// Ports:
//   clk  sole clock, rising edge
//   rst  asynchronous active-high reset
//   bus  cla_acc_if.slave (handshake, adder operands/result, status)
// Parameter:
//   SETTLE_CYCLES  adder settle time in cycles, 1..15
// Optional build macro:
//   CLA_ACC_SAT_EN  a capture with carry-out loads 8'hFF instead of wrapping
module cla_acc_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic      clk,
  input  logic      rst,
  cla_acc_if.slave  bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
`ifdef CLA_ACC_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  state_t     state, state_n;
  logic [7:0] opnd_p0;
  logic [3:0] cnt_p0;
  logic [7:0] acc_p1;
  logic       vld_p1;
  logic [7:0] carry_cnt_p1;
  logic       ovf_p1;
  logic       ready_c;
  logic       accept;
  logic       capture;

  function automatic logic [7:0] capture_val(input logic [7:0] sum,
                                             input logic       cout,
                                             input logic       sat_en);
    return (sat_en && cout) ? 8'hFF : sum;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    ready_c = (state == IDLE) && !bus.clear;
    accept  = bus.in_valid && ready_c;
    capture = (state == WAIT) && (cnt_p0 == 4'd0) && !bus.clear;
    if (bus.clear)    state_n = IDLE;
    else if (accept)  state_n = WAIT;
    else if (capture) state_n = IDLE;
  end

  // Stage p0: operand register and settle counter; stage p1: captured result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opnd_p0      <= 8'h00;
      cnt_p0       <= 4'd0;
      acc_p1       <= 8'h00;
      vld_p1       <= 1'b0;
      carry_cnt_p1 <= 8'h00;
      ovf_p1       <= 1'b0;
    end else if (bus.clear) begin
      // Aborts any in-flight operation; operand register is left as is.
      acc_p1       <= 8'h00;
      vld_p1       <= 1'b0;
      carry_cnt_p1 <= 8'h00;
      ovf_p1       <= 1'b0;
    end else begin
      vld_p1 <= capture;
      if (accept) begin
        opnd_p0 <= bus.in_data;
        cnt_p0  <= CNT_INIT;
      end else if (state == WAIT && cnt_p0 != 4'd0) begin
        cnt_p0 <= cnt_p0 - 4'd1;
      end
      if (capture) begin
        acc_p1 <= capture_val(bus.add_sum, bus.add_cout, SAT_EN);
        if (bus.add_cout) begin
          carry_cnt_p1 <= sat_inc(carry_cnt_p1);
          ovf_p1       <= 1'b1;
        end
      end
    end
  end

  // in_ready is gated by rst directly so it stays low for the whole reset.
  assign bus.in_ready  = ready_c && !rst;
  assign bus.add_a     = acc_p1;
  assign bus.add_b     = opnd_p0;
  assign bus.acc       = acc_p1;
  assign bus.out_valid = vld_p1;
  assign bus.carry_cnt = carry_cnt_p1;
  assign bus.ovf       = ovf_p1;

endmodule

// File: tb/tb_cla_acc_ctrl.sv
// tb_cla_acc_ctrl -- directed self-checking bench for cla_acc_ctrl
// (SETTLE_CYCLES=2) with a behavioural model of the external adder.
// Honours CLA_ACC_SAT_EN for the saturating-capture expectations.
module tb_cla_acc_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  logic       ovr = 1'b0;
  logic [7:0] ovr_sum = 8'h00;
  logic       ovr_cout = 1'b0;
  logic [8:0] model_res;

  cla_acc_if ifc();

  cla_acc_ctrl #(.SETTLE_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  // External adder: plain 8-bit add, or a forced result for carry tests.
  assign model_res    = {1'b0, ifc.add_a} + {1'b0, ifc.add_b};
  assign ifc.add_sum  = ovr ? ovr_sum  : model_res[7:0];
  assign ifc.add_cout = ovr ? ovr_cout : model_res[8];

`ifdef CLA_ACC_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  // Offer one operand, return edges from accept to visible out_valid (-1 = none).
  task automatic do_op(input logic [7:0] d, output int lat);
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ifc.out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    ifc.clear = 1'b1;
    @(negedge clk);
    ifc.clear = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total_cnt++;
    if ({ifc.acc, ifc.carry_cnt, ifc.ovf, ifc.out_valid} !== 18'h0) $display("FAIL reset_state acc=%h cnt=%h ovf=%b ov=%b required 0", ifc.acc, ifc.carry_cnt, ifc.ovf, ifc.out_valid);
    else pass_cnt++;
    total_cnt++;
    if ({ifc.add_a, ifc.add_b} !== 16'h0) $display("FAIL reset_operands a=%h b=%h required 0", ifc.add_a, ifc.add_b);
    else pass_cnt++;
    total_cnt++;
    if (ifc.in_ready !== 1'b0) $display("FAIL reset_ready got %b required 0", ifc.in_ready);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++;
    if (ifc.in_ready !== 1'b1) $display("FAIL ready_after_reset got %b required 1", ifc.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int lat;
    do_op(8'h05, lat);
    total_cnt++;
    if (lat !== 2) $display("FAIL lat_05 got %0d required 2", lat);
    else pass_cnt++;
    total_cnt++;
    if (ifc.acc !== 8'h05) $display("FAIL acc_05 got %h required 05", ifc.acc);
    else pass_cnt++;
    do_op(8'h0A, lat);
    total_cnt++;
    if (lat !== 2) $display("FAIL lat_0a got %0d required 2", lat);
    else pass_cnt++;
    total_cnt++;
    if (ifc.acc !== 8'h0F || ifc.ovf !== 1'b0) $display("FAIL acc_0f got %h ovf=%b required 0f ovf=0", ifc.acc, ifc.ovf);
    else pass_cnt++;
    // Operands must stay stable across both WAIT cycles.
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.in_data  = 8'h3C;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      ifc.in_valid = 1'b0;
      ifc.in_data  = 8'hAA;
      total_cnt++;
      if (ifc.add_a !== 8'h0F || ifc.add_b !== 8'h3C || ifc.in_ready !== 1'b0) $display("FAIL hold_%0d a=%h b=%h rdy=%b required 0f 3c 0", i, ifc.add_a, ifc.add_b, ifc.in_ready);
      else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++;
    if (ifc.acc !== 8'h4B || ifc.out_valid !== 1'b1) $display("FAIL acc_4b got %h ov=%b required 4b ov=1", ifc.acc, ifc.out_valid);
    else pass_cnt++;
  endtask

  task automatic test_carry();
    int lat;
    logic [7:0] exp_acc;
    do_clear();
    do_op(8'hF0, lat);
    total_cnt++;
    if (ifc.acc !== 8'hF0 || ifc.carry_cnt !== 8'h00) $display("FAIL acc_f0 got %h cnt=%h required f0 cnt=00", ifc.acc, ifc.carry_cnt);
    else pass_cnt++;
    do_op(8'h20, lat);
    exp_acc = SAT ? 8'hFF : 8'h10;
    total_cnt++;
    if (ifc.acc !== exp_acc) $display("FAIL acc_carry got %h required %h", ifc.acc, exp_acc);
    else pass_cnt++;
    total_cnt++;
    if (ifc.carry_cnt !== 8'h01 || ifc.ovf !== 1'b1) $display("FAIL carry_flags cnt=%h ovf=%b required 01 1", ifc.carry_cnt, ifc.ovf);
    else pass_cnt++;
  endtask

  task automatic test_hold_valid();
    int accepts = 0;
    int pulses  = 0;
    int low     = 0;
    do_clear();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifc.out_valid) pulses++;
      if (!ifc.in_ready) low++;
      if (accepts < 4) begin
        ifc.in_valid = 1'b1;
        ifc.in_data  = 8'h01;
        if (ifc.in_ready) accepts++;
      end else begin
        ifc.in_valid = 1'b0;
      end
    end
    total_cnt++;
    if (pulses !== 4) $display("FAIL pulse_count got %0d required 4", pulses);
    else pass_cnt++;
    total_cnt++;
    if (low !== 8) $display("FAIL ready_low_cycles got %0d required 8", low);
    else pass_cnt++;
    total_cnt++;
    if (ifc.acc !== 8'h04) $display("FAIL acc_four got %h required 04", ifc.acc);
    else pass_cnt++;
  endtask

  task automatic test_clear_midwait();
    int pulses = 0;
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.in_data  = 8'h33;
    @(negedge clk);
    ifc.in_valid = 1'b0;
    ifc.clear    = 1'b1;
    #1;
    total_cnt++;
    if (ifc.in_ready !== 1'b0) $display("FAIL ready_during_clear got %b required 0", ifc.in_ready);
    else pass_cnt++;
    @(negedge clk);
    ifc.clear = 1'b0;
    #1;
    total_cnt++;
    if ({ifc.acc, ifc.carry_cnt, ifc.ovf, ifc.out_valid} !== 18'h0 || ifc.in_ready !== 1'b1) $display("FAIL after_clear acc=%h cnt=%h ovf=%b ov=%b rdy=%b required 0 0 0 0 1", ifc.acc, ifc.carry_cnt, ifc.ovf, ifc.out_valid, ifc.in_ready);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ifc.out_valid) pulses++;
    end
    total_cnt++;
    if (pulses !== 0 || ifc.acc !== 8'h00) $display("FAIL clear_abort pulses=%0d acc=%h required 0 00", pulses, ifc.acc);
    else pass_cnt++;
  endtask

  task automatic test_rst_midwait();
    int lat;
    int pulses = 0;
    do_op(8'h11, lat);
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.in_data  = 8'h07;
    @(negedge clk);
    ifc.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({ifc.acc, ifc.add_a, ifc.add_b} !== 24'h0 || ifc.in_ready !== 1'b0) $display("FAIL async_rst acc=%h a=%h b=%h rdy=%b required 0 0 0 0", ifc.acc, ifc.add_a, ifc.add_b, ifc.in_ready);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ifc.out_valid) pulses++;
    end
    total_cnt++;
    if (pulses !== 0 || ifc.acc !== 8'h00 || ifc.in_ready !== 1'b1) $display("FAIL rst_abort pulses=%0d acc=%h rdy=%b required 0 00 1", pulses, ifc.acc, ifc.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_carry_sat();
    int lat;
    int bad_lat = 0;
    logic [7:0] exp_acc;
    ovr      = 1'b1;
    ovr_sum  = 8'h5A;
    ovr_cout = 1'b1;
    for (int i = 0; i < 300; i++) begin
      do_op(8'h01, lat);
      if (lat != 2) bad_lat++;
      if (i == 253) begin
        total_cnt++;
        if (ifc.carry_cnt !== 8'hFE) $display("FAIL carry_254 got %h required fe", ifc.carry_cnt);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (bad_lat !== 0) $display("FAIL sat_latency bad=%0d required 0", bad_lat);
    else pass_cnt++;
    exp_acc = SAT ? 8'hFF : 8'h5A;
    total_cnt++;
    if (ifc.carry_cnt !== 8'hFF || ifc.ovf !== 1'b1 || ifc.acc !== exp_acc) $display("FAIL carry_sat cnt=%h ovf=%b acc=%h required ff 1 %h", ifc.carry_cnt, ifc.ovf, ifc.acc, exp_acc);
    else pass_cnt++;
    ovr_cout = 1'b0;
    do_op(8'h01, lat);
    total_cnt++;
    if (ifc.ovf !== 1'b1 || ifc.carry_cnt !== 8'hFF || ifc.acc !== 8'h5A) $display("FAIL ovf_sticky ovf=%b cnt=%h acc=%h required 1 ff 5a", ifc.ovf, ifc.carry_cnt, ifc.acc);
    else pass_cnt++;
    ovr = 1'b0;
    do_clear();
    total_cnt++;
    if (ifc.ovf !== 1'b0 || ifc.carry_cnt !== 8'h00) $display("FAIL ovf_cleared ovf=%b cnt=%h required 0 00", ifc.ovf, ifc.carry_cnt);
    else pass_cnt++;
  endtask

  initial begin
    ifc.clear    = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'h00;
    test_reset();
    test_basic();
    test_carry();
    test_hold_valid();
    test_clear_midwait();
    test_rst_midwait();
    test_carry_sat();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not complete required finish before 200000");
    $fatal(1);
  end

endmodule
